// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: state encoding and default pattern table for pattern_seq_ctrl
package pattern_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam int DEF_TAB [4] = '{0, 2, 5, 7};
    function automatic int def_entry(input int i);
        return (i < 4) ? DEF_TAB[i[1:0]] : 0;
    endfunction
endpackage

// File: rtl/pattern_table.sv
// pattern_table: pattern storage with reset defaults, synchronous write, asynchronous read
module pattern_table
    import pattern_seq_pkg::*;
#(
    parameter int W = 3,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= W'(def_entry(i));
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pattern_seq_ctrl.sv
// pattern_seq_ctrl: plays table entries 0..len repeatedly for rep passes with pause/abort control
module pattern_seq_ctrl
    import pattern_seq_pkg::*;
#(
    parameter int W = 3,
    parameter int DEPTH = 4,
    parameter int REPW = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [W-1:0]    cfg_data,
    input  logic [AW-1:0]   len,
    input  logic [REPW-1:0] rep,
    input  logic            start,
    input  logic            pause,
    input  logic            abort,
    output logic [W-1:0]    count,
    output logic            count_vld,
    output logic            busy,
    output logic            done,
    output logic [REPW-1:0] iter
);
    state_t st, st_n;
    logic [AW-1:0] idx, idx_n, len_q;
    logic [REPW-1:0] rep_q, iter_n, iter_inc;
    logic [W-1:0] rdata, count_n;
    logic vld_n, busy_n, done_n, go, adv, wrap, fin;

    assign go = st == IDLE && start && !abort;
    assign adv = (st == RUN || st == PAUSE) && !pause && !abort;
    assign wrap = idx == len_q;
    assign iter_inc = iter + REPW'(1);
    assign fin = wrap && rep_q != '0 && iter_inc == rep_q;
    // the table is read at the next index so count is registered alongside it
    assign idx_n = (go || (adv && wrap)) ? '0 : adv ? idx + AW'(1) : idx;

    pattern_table #(.W(W), .DEPTH(DEPTH)) u_tab (
        .clk  (clk),
        .rst  (rst),
        .we   (cfg_we && (st == IDLE || st == DONE)),
        .waddr(cfg_addr),
        .wdata(cfg_data),
        .raddr(idx_n),
        .rdata(rdata)
    );

    always_comb begin
        st_n = st;
        count_n = count;
        vld_n = 1'b0;
        done_n = 1'b0;
        iter_n = iter;
        if (abort) begin
            st_n = IDLE;
            count_n = '0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    st_n = RUN;
                    count_n = rdata;
                    vld_n = 1'b1;
                    iter_n = '0;
                end
                RUN, PAUSE: if (pause) begin
                    st_n = PAUSE;
                end else if (fin) begin
                    st_n = DONE;
                    done_n = 1'b1;
                    iter_n = iter_inc;
                end else begin
                    st_n = RUN;
                    count_n = rdata;
                    vld_n = 1'b1;
                    iter_n = wrap ? iter_inc : iter;
                end
                default: st_n = IDLE;
            endcase
        end
        busy_n = st_n == RUN || st_n == PAUSE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            idx <= '0;
            len_q <= '0;
            rep_q <= '0;
            count <= '0;
            count_vld <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            iter <= '0;
        end else begin
            st <= st_n;
            idx <= idx_n;
            count <= count_n;
            count_vld <= vld_n;
            busy <= busy_n;
            done <= done_n;
            iter <= iter_n;
            if (go) begin
                len_q <= len;
                rep_q <= rep;
            end
        end
    end
endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb_pattern_seq_ctrl: vector table plus hand sequences, checked through an expected-output queue
module tb_pattern_seq_ctrl;
    logic clk = 1'b0;
    logic rst, cfg_we, start, pause, abort, count_vld, busy, done;
    logic [1:0] cfg_addr, len;
    logic [2:0] cfg_data, count;
    logic [3:0] rep, iter;
    int total = 0, bad = 0;
    logic [9:0] sb [$];

    typedef struct {
        logic r, s, p, a;
        int c, v, b, d, i;
    } vec_t;
    vec_t vt [27];
    int def_tab [4] = '{0, 2, 5, 7};
    int new_tab [4] = '{1, 3, 4, 6};

    always #5 clk = ~clk;

    pattern_seq_ctrl #(.W(3), .DEPTH(4), .REPW(4)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .len(len), .rep(rep), .start(start), .pause(pause), .abort(abort),
        .count(count), .count_vld(count_vld), .busy(busy), .done(done), .iter(iter)
    );

    function automatic logic [9:0] o(input int c, v, b, d, i);
        return {3'(c), 1'(v), 1'(b), 1'(d), 4'(i)};
    endfunction

    task automatic tick(input logic [9:0] e, input string nm);
        logic [9:0] got, exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        got = {count, count_vld, busy, done, iter};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got cnt=%0d vld=%b busy=%b done=%b iter=%0d, want cnt=%0d vld=%b busy=%b done=%b iter=%0d",
                     nm, got[9:7], got[6], got[5], got[4], got[3:0], exp[9:7], exp[6], exp[5], exp[4], exp[3:0]);
        end
        {rst, start, pause, abort, cfg_we} = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        {rst, start, pause, abort, cfg_we} = '0;
        cfg_addr = '0; cfg_data = '0; len = 2'd3; rep = 4'd1;
        vt[0]  = '{1,0,0,0, 0,0,0,0,0};
        vt[1]  = '{0,1,0,0, 0,1,1,0,0};
        vt[2]  = '{0,0,0,0, 2,1,1,0,0};
        vt[3]  = '{0,0,0,0, 5,1,1,0,0};
        vt[4]  = '{0,0,0,0, 7,1,1,0,0};
        vt[5]  = '{0,0,0,0, 7,0,0,1,1};
        vt[6]  = '{0,0,0,0, 7,0,0,0,1};
        vt[7]  = '{0,1,0,0, 0,1,1,0,0};
        vt[8]  = '{0,0,0,0, 2,1,1,0,0};
        vt[9]  = '{0,0,1,0, 2,0,1,0,0};
        vt[10] = '{0,0,1,0, 2,0,1,0,0};
        vt[11] = '{0,0,1,0, 2,0,1,0,0};
        vt[12] = '{0,0,0,0, 5,1,1,0,0};
        vt[13] = '{0,0,0,0, 7,1,1,0,0};
        vt[14] = '{0,0,0,0, 7,0,0,1,1};
        vt[15] = '{0,0,0,0, 7,0,0,0,1};
        vt[16] = '{0,1,0,0, 0,1,1,0,0};
        vt[17] = '{0,0,0,0, 2,1,1,0,0};
        vt[18] = '{0,0,0,0, 5,1,1,0,0};
        vt[19] = '{0,0,0,1, 0,0,0,0,0};
        vt[20] = '{0,0,0,0, 0,0,0,0,0};
        vt[21] = '{0,1,0,1, 0,0,0,0,0};
        vt[22] = '{0,0,0,0, 0,0,0,0,0};
        vt[23] = '{0,1,0,0, 0,1,1,0,0};
        vt[24] = '{0,1,0,0, 2,1,1,0,0};
        vt[25] = '{0,1,1,0, 2,0,1,0,0};
        vt[26] = '{0,1,1,1, 0,0,0,0,0};
        @(negedge clk);
        for (int k = 0; k < 27; k++) begin
            rst = vt[k].r; start = vt[k].s; pause = vt[k].p; abort = vt[k].a;
            tick(o(vt[k].c, vt[k].v, vt[k].b, vt[k].d, vt[k].i), $sformatf("vec%0d", k));
        end

        for (int k = 0; k < 4; k++) begin
            cfg_we = 1'b1; cfg_addr = 2'(k); cfg_data = 3'(new_tab[k]);
            tick(o(0,0,0,0,0), "cfg_idle");
        end
        len = 2'd2; rep = 4'd2; start = 1'b1;
        tick(o(1,1,1,0,0), "r2_p0_e0");
        tick(o(3,1,1,0,0), "r2_p0_e1");
        tick(o(4,1,1,0,0), "r2_p0_e2");
        tick(o(1,1,1,0,1), "r2_p1_e0");
        tick(o(3,1,1,0,1), "r2_p1_e1");
        tick(o(4,1,1,0,1), "r2_p1_e2");
        tick(o(4,0,0,1,2), "r2_done");
        tick(o(4,0,0,0,2), "r2_idle");

        start = 1'b1;
        tick(o(1,1,1,0,0), "we_run_start");
        for (int k = 0; k < 3; k++) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 3'd7;
            tick(o(k == 0 ? 3 : k == 1 ? 4 : 1, 1, 1, 0, k == 2 ? 1 : 0), "we_run_ignored");
        end
        rst = 1'b1;
        tick(o(0,0,0,0,0), "rst_mid_run");

        len = 2'd3; rep = 4'd0; start = 1'b1;
        tick(o(0,1,1,0,0), "rep0_start");
        for (int k = 1; k <= 64; k++) tick(o(def_tab[k % 4], 1, 1, 0, (k / 4) % 16), $sformatf("rep0_c%0d", k));
        abort = 1'b1;
        tick(o(0,0,0,0,0), "rep0_abort");

        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 3'd6;
        tick(o(0,0,0,0,0), "len0_cfg");
        len = 2'd0; rep = 4'd3; start = 1'b1;
        tick(o(6,1,1,0,0), "len0_c0");
        tick(o(6,1,1,0,1), "len0_c1");
        tick(o(6,1,1,0,2), "len0_c2");
        tick(o(6,0,0,1,3), "len0_done");
        tick(o(6,0,0,0,3), "len0_idle");

        len = 2'd3; rep = 4'd1; start = 1'b1;
        tick(o(6,1,1,0,0), "rst2_run0");
        tick(o(2,1,1,0,0), "rst2_run1");
        rst = 1'b1; start = 1'b1; abort = 1'b1; cfg_we = 1'b1;
        tick(o(0,0,0,0,0), "rst_override");
        start = 1'b1;
        tick(o(0,1,1,0,0), "deftab_e0");
        tick(o(2,1,1,0,0), "deftab_e1");
        abort = 1'b1;
        tick(o(0,0,0,0,0), "final_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
